iir_inverse_eq: RTL and testbench
=================================

# iir_inverse_eq

Inverse (equalising) filter for the 32-bit recursive shaping filter y[n] = x[n-1] − x[n-2] + x[n-3] + x[n-4] + (y[n-1]>>1) + (y[n-2]>>2). It sits at the receive end of that filter and reconstructs the original sample stream x exactly, in modulo-2^W arithmetic, from the filtered stream y. It adds a valid/ready handshake with a one-deep output stage, and discards the initial one-sample filter delay, so output sample k equals x[k].

## Interface
- W, 32, sample width; all arithmetic is modulo 2^W, unsigned.
- clk  in  1  rising-edge clock.
- rst_a  in  1  asynchronous, active-high reset.
- clr  in  1  synchronous clear of all filter state; same effect as reset.
- in_valid  in  1  in_data holds a filtered sample y[n].
- in_ready  out  1  block can accept a sample this cycle.
- in_data  in  W  filtered sample y[n].
- out_valid  out  1  out_data holds a reconstructed sample.
- out_ready  in  1  downstream accepts out_data this cycle.
- out_data  out  W  reconstructed sample x[k].
- out_cnt  out  32  number of output samples accepted downstream (INVFILT_CNT_EN only).

## Operation
- State registers (all W bits, reset to 0):
  - yd1 = y[n-1], yd2 = y[n-2].
  - xr1 = x[n-2], xr2 = x[n-3], xr3 = x[n-4].
- Also held: primed flag (reset 0) and the output register (out_valid, out_data).
- Shifts are logical, with zero fill, on the unsigned value. This must match the forward filter exactly.
- Accept condition: in_valid && in_ready. in_ready = !out_valid || out_ready, which is combinational from out_ready.
- On accept of y[n]:
  - Compute xh = y[n] − (yd1>>1) − (yd2>>2) + xr1 − xr2 − xr3 (mod 2^W). The result xh equals x[n-1].
  - Shift the histories: yd2←yd1, yd1←y[n]; xr3←xr2, xr2←xr1, xr1←xh.
  - If primed = 0: set primed←1. xh (which is x[-1] = 0) is discarded and out_valid is not set.
  - If primed = 1: out_data←xh and out_valid←1.
- Output handshake:
  - out_valid && out_ready with no accept in the same cycle → out_valid←0.
  - Both in the same cycle → out_valid stays 1 and out_data takes the new value, giving full throughput.
- While out_valid && !out_ready: in_ready = 0, and out_data and all state hold unchanged.
- clr = 1, or rst_a = 1 mid-stream:
  - All state, primed, out_valid and out_cnt go to 0.
  - Any pending output is dropped.
  - A sample presented in the same cycle as clr is not consumed, even though in_ready may be 1.
- Reset values of outputs: out_valid = 0, out_data = 0, out_cnt = 0. in_ready = 1 after reset.

## Timing
- Latency: x[k] appears on out_data/out_valid in the cycle after y[k+1] is accepted.
- With in_valid = 1 and out_ready = 1 every cycle, the block sustains 1 sample per clock.
- Back-to-back stall/release is lossless: no sample is duplicated or skipped.
- There are no combinational paths from in_data to out_data. The only combinational path is out_ready → in_ready.
- The single-cycle arithmetic path is 5 W-bit add/subtract operations. No internal pipelining is required at W ≤ 32.

## Configuration
- INVFILT_CNT_EN:
  - Defined: the out_cnt port exists. It increments by 1 on each out_valid && out_ready, wraps from 2^32−1 to 0, and is cleared by rst_a and clr.
  - Undefined: the out_cnt port and its counter are absent. All other behaviour is identical.

## Test plan
- Impulse recovery: accept y = 0, 1, 0xFFFFFFFF, 0x80000000 with out_ready = 1 → outputs exactly 1, 0, 0. There is no output after the first accept.
- Chained exactness: a reference model of the forward filter is driven with 10 000 random 32-bit x, including 0xFFFFFFFF and 0x80000000, and its y is fed to the block one per cycle → out_data sequence equals the x sequence bit-exactly, with x[k] appearing one cycle after accept of y[k+1].
- Backpressure: same stream with out_ready toggled randomly at 50% →
  - in_ready low exactly while out_valid && !out_ready.
  - out_data stable while stalled.
  - Output sequence unchanged.
- Mid-stream clear: after 5 samples, assert clr together with in_valid for one cycle, then restart with the impulse vector →
  - out_valid = 0 the cycle after clr.
  - The sample presented with clr is not consumed.
  - Outputs 1, 0, 0 again.
- Async reset: assert rst_a between clock edges with out_valid = 1 →
  - out_valid and out_data go to 0 immediately, without waiting for a clock edge.
  - After release, the first output again corresponds to the second accepted sample.
- Counter (INVFILT_CNT_EN): deliver 3 outputs → out_cnt = 3. Force the counter to 0xFFFFFFFF and deliver 1 output → out_cnt = 0. clr → out_cnt = 0.

Source files
------------

// File: rtl/iir_inverse_eq_if.sv
// Stream bundle for iir_inverse_eq.
// Carries both the input (filtered y) and output (reconstructed x) handshakes.
// master: the environment side (upstream source plus downstream sink).
// slave: the equaliser itself.
interface iir_inverse_eq_if #(
  parameter int unsigned W = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
  );
endinterface

// File: rtl/iir_inverse_eq.sv
// iir_inverse_eq: exact modulo-2^W inverse of the recursive shaping filter
//   y[n] = x[n-1] - x[n-2] + x[n-3] + x[n-4] + (y[n-1]>>1) + (y[n-2]>>2)
// Each accepted y[n] yields x[n-1]. The very first result (x[-1]) is dropped,
// so output sample k is x[k]. The output stage is one register deep and
// in_ready is the only combinational path (from out_ready).
// Optional feature macro: INVFILT_CNT_EN adds the out_cnt delivery counter.
module iir_inverse_eq #(
  parameter int unsigned W = 32
) (
  input  logic                 clk,
  input  logic                 rst_a,
  input  logic                 clr,
  iir_inverse_eq_if.slave      bus
`ifdef INVFILT_CNT_EN
  ,
  output logic [31:0]          out_cnt
`endif
);

  typedef enum logic [0:0] {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t       state_q;
  state_t       state_d;

  logic [W-1:0] yd1;
  logic [W-1:0] yd2;
  logic [W-1:0] xr1;
  logic [W-1:0] xr2;
  logic [W-1:0] xr3;

  logic         out_valid_q;
  logic [W-1:0] out_data_q;

  logic         in_ready;
  logic         accept;
  logic         deliver;
  logic         emit;
  logic [W-1:0] xh;

  // Handshake decode and the single-cycle reconstruction of x[n-1].
  // clr masks accept so a sample presented alongside it is never consumed.
  always_comb begin
    in_ready = !out_valid_q || bus.out_ready;
    accept   = bus.in_valid && in_ready && !clr;
    deliver  = out_valid_q && bus.out_ready;
    xh       = bus.in_data - (yd1 >> 1) - (yd2 >> 2) + xr1 - xr2 - xr3;
  end

  // Priming FSM: the first accept after reset/clear fills history only.
  always_comb begin
    state_d = state_q;
    emit    = 1'b0;
    case (state_q)
      ST_FILL: begin
        if (accept) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        emit = accept;
      end
      default: begin
        state_d = ST_FILL;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      state_q <= ST_FILL;
    end else if (clr) begin
      state_q <= ST_FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // Input/output history shift on every accepted sample.
  always_ff @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      yd1 <= '0;
      yd2 <= '0;
      xr1 <= '0;
      xr2 <= '0;
      xr3 <= '0;
    end else if (clr) begin
      yd1 <= '0;
      yd2 <= '0;
      xr1 <= '0;
      xr2 <= '0;
      xr3 <= '0;
    end else if (accept) begin
      yd2 <= yd1;
      yd1 <= bus.in_data;
      xr3 <= xr2;
      xr2 <= xr1;
      xr1 <= xh;
    end
  end

  // One-deep output register; a new result and a delivery in the same
  // cycle keep out_valid high so the stream runs at one sample per clock.
  always_ff @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (clr) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (emit) begin
      out_valid_q <= 1'b1;
      out_data_q  <= xh;
    end else if (deliver) begin
      out_valid_q <= 1'b0;
    end
  end

`ifdef INVFILT_CNT_EN
  logic [31:0] cnt_q;

  // Count samples taken downstream; wraps naturally at 2^32.
  always_ff @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (deliver) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign out_cnt = cnt_q;
`endif

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;

endmodule

// File: tb/tb_iir_inverse_eq.sv
// Self-checking bench for iir_inverse_eq: a forward-filter reference model
// produces y from random x, expected x values go into a scoreboard queue on
// accept and are compared when the DUT hands them downstream.
module tb_iir_inverse_eq;

  logic clk = 1'b0;
  logic rst_a;
  logic clr;

  iir_inverse_eq_if #(.W(32)) bus ();

`ifdef INVFILT_CNT_EN
  logic [31:0] out_cnt;
`endif

  iir_inverse_eq #(.W(32)) dut (
    .clk   (clk),
    .rst_a (rst_a),
    .clr   (clr),
    .bus   (bus)
`ifdef INVFILT_CNT_EN
    ,
    .out_cnt (out_cnt)
`endif
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // Scoreboard and behavioural model of the handshake.
  logic [31:0] q[$];
  logic        exp_valid = 1'b0;
  logic        m_primed  = 1'b0;
  logic [31:0] exp_cnt   = '0;
  logic        stall_prev = 1'b0;
  logic [31:0] stall_data = '0;

  // Forward shaping-filter reference state.
  logic [31:0] fx1, fx2, fx3, fx4, fy1, fy2;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_valid  = 1'b0;
    m_primed   = 1'b0;
    exp_cnt    = '0;
    stall_prev = 1'b0;
    q.delete();
  endtask

  task automatic fwd_reset();
    fx1 = '0; fx2 = '0; fx3 = '0; fx4 = '0; fy1 = '0; fy2 = '0;
  endtask

  // Produce y[n] from history, return x[n-1] as the value it should decode to,
  // then take x[n] into the history.
  task automatic fwd_step(input logic [31:0] x_new, output logic [31:0] y, output logic [31:0] x_prev);
    y      = fx1 - fx2 + fx3 + fx4 + (fy1 >> 1) + (fy2 >> 2);
    x_prev = fx1;
    fy2 = fy1; fy1 = y;
    fx4 = fx3; fx3 = fx2; fx2 = fx1; fx1 = x_new;
  endtask

  // One clock cycle, entered and left at the falling edge.
  task automatic step(input logic v, input logic [31:0] d, input logic ordy,
                      input logic c, input logic [31:0] ex, output logic acc);
    logic hs;
    logic prim_old;
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = ordy;
    clr           = c;
    #1;
    check("out_valid", {31'b0, bus.out_valid}, {31'b0, exp_valid});
    check("in_ready", {31'b0, bus.in_ready}, {31'b0, (!exp_valid || ordy)});
    if (stall_prev) check("stall_hold", bus.out_data, stall_data);
    hs = exp_valid && ordy;
    if (hs) begin
      n_cmp++;
      assert (q.size() != 0) else begin
        n_err++;
        $error("FAIL sb_empty observed=%h expected=queued_value", bus.out_data);
      end
      if (q.size() != 0) check("out_data", bus.out_data, q.pop_front());
    end
    acc        = v && (!exp_valid || ordy) && !c;
    stall_prev = exp_valid && !ordy && !c;
    stall_data = bus.out_data;
    prim_old   = m_primed;
    @(posedge clk);
    if (c) begin
      model_reset();
    end else begin
      if (hs) exp_cnt = exp_cnt + 32'd1;
      if (acc && prim_old) begin
        q.push_back(ex);
        exp_valid = 1'b1;
      end else if (hs) begin
        exp_valid = 1'b0;
      end
      if (acc) m_primed = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic send(input logic [31:0] y, input logic [31:0] ex, input logic bp);
    logic acc;
    acc = 1'b0;
    for (int t = 0; t < 64 && !acc; t++) begin
      step(1'b1, y, bp ? 1'($urandom_range(0, 1)) : 1'b1, 1'b0, ex, acc);
    end
    if (!acc) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    logic acc;
    for (int t = 0; t < 8 && (exp_valid || q.size() != 0); t++) begin
      step(1'b0, '0, 1'b1, 1'b0, '0, acc);
    end
    check("drained", q.size(), 32'd0);
  endtask

  task automatic do_clear();
    logic acc;
    step(1'b1, 32'h0001_2345, 1'b1, 1'b1, '0, acc);
    fwd_reset();
  endtask

  task automatic impulse();
    send(32'h0000_0000, 32'd0, 1'b0);
    send(32'h0000_0001, 32'd1, 1'b0);
    send(32'hFFFF_FFFF, 32'd0, 1'b0);
    send(32'h8000_0000, 32'd0, 1'b0);
  endtask

  task automatic stream(input int unsigned n, input logic bp);
    logic [31:0] x, y, xp;
    for (int unsigned i = 0; i < n; i++) begin
      if (i % 97 == 5)      x = 32'hFFFF_FFFF;
      else if (i % 89 == 7) x = 32'h8000_0000;
      else                  x = $urandom;
      fwd_step(x, y, xp);
      send(y, xp, bp);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc;
    rst_a         = 1'b1;
    clr           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    fwd_reset();
    model_reset();
    repeat (2) @(negedge clk);
    rst_a = 1'b0;
    #1;
    check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("rst_out_data", bus.out_data, 32'd0);
    check("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
`ifdef INVFILT_CNT_EN
    check("rst_out_cnt", out_cnt, 32'd0);
`endif
    @(negedge clk);

    // Impulse recovery: outputs 1, 0, 0, nothing after the first accept.
    impulse();
    drain();

    // Chained exactness at full throughput.
    do_clear();
    stream(10000, 1'b0);
    drain();

    // Random backpressure on the downstream side.
    stream(3000, 1'b1);
    drain();

    // Mid-stream clear with a sample presented alongside it.
    stream(5, 1'b0);
    do_clear();
    impulse();
    drain();

    // Async reset between clock edges while an output is pending.
    do_clear();
    step(1'b1, 32'd0, 1'b1, 1'b0, 32'd0, acc);
    step(1'b1, 32'd1, 1'b0, 1'b0, 32'd1, acc);
    #2;
    rst_a = 1'b1;
    #1;
    check("arst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("arst_out_data", bus.out_data, 32'd0);
    model_reset();
    fwd_reset();
    @(negedge clk);
    rst_a = 1'b0;
    impulse();
    drain();

`ifdef INVFILT_CNT_EN
    do_clear();
    impulse();
    drain();
    check("cnt_three", out_cnt, 32'd3);
    force dut.cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.cnt_q;
    exp_cnt = 32'hFFFF_FFFF;
    // Fifth impulse-response sample decodes to x[3] = 0.
    send(32'h8000_0000, 32'd0, 1'b0);
    drain();
    check("cnt_wrap", out_cnt, exp_cnt);
    check("cnt_wrap_zero", out_cnt, 32'd0);
    do_clear();
    check("cnt_clr", out_cnt, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
